// File: rtl/core_irq_ctrl.sv
// core_irq_ctrl: Avalon-MM interrupt aggregator with pending/mask/edge regs.
// Optional macro CORE_IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on irq_in.
module core_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [3:0]         irq_id
);

    localparam logic [15:0] USED = 16'((32'd1 << NUM_IRQ) - 32'd1);

    logic [15:0] in_ext;
    logic [15:0] s_in;
    logic [15:0] prev;
    logic [15:0] pending;
    logic [15:0] mask;
    logic [15:0] edge_sel;

    logic        wr0, wr1, wr2, wr3;
    logic [15:0] set;
    logic [15:0] pending_next;
    logic [15:0] mask_next;
    logic [15:0] edge_next;
    logic [15:0] act_next;
    logic [15:0] act_cur;
    logic [15:0] rd_next;

    assign in_ext = 16'(irq_in);

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] id;
        id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) id = 4'(i);
        end
        return id;
    endfunction

`ifdef CORE_IRQ_CTRL_SYNC_EN
    logic [15:0] sync1;
    logic [15:0] sync2;

    // Two-flop synchronizer for asynchronous peripheral irq lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 16'h0000;
            sync2 <= 16'h0000;
        end else begin
            sync1 <= in_ext;
            sync2 <= sync1;
        end
    end

    assign s_in = sync2;
`else
    assign s_in = in_ext;
`endif

    // Register-write decode and next-state of pending/mask/edge
    always_comb begin
        wr0 = chipselect && !write_n && (address == 3'd0);
        wr1 = chipselect && !write_n && (address == 3'd1);
        wr2 = chipselect && !write_n && (address == 3'd2);
        wr3 = chipselect && !write_n && (address == 3'd3);

        set = (edge_sel & s_in & ~prev)
            | (~edge_sel & s_in)
            | (wr3 ? writedata : 16'h0000);

        pending_next = ((pending & ~(wr0 ? writedata : 16'h0000)) | set) & USED;
        mask_next    = wr1 ? (writedata & USED) : mask;
        edge_next    = wr2 ? (writedata & USED) : edge_sel;
        act_next     = pending_next & mask_next;
        act_cur      = pending & mask;
    end

    // Read mux on pre-write register state
    always_comb begin
        rd_next = 16'h0000;
        case (address)
            3'd0:    rd_next = pending;
            3'd1:    rd_next = mask;
            3'd2:    rd_next = edge_sel;
            3'd3:    rd_next = act_cur;
            3'd4:    rd_next = {|act_cur, 11'b0, lowest(act_cur)};
            3'd5:    rd_next = s_in & USED;
            default: rd_next = 16'h0000;
        endcase
    end

    // State registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0000;
            irq      <= 1'b0;
            irq_id   <= 4'd0;
            pending  <= 16'h0000;
            mask     <= 16'h0000;
            edge_sel <= 16'h0000;
            prev     <= 16'h0000;
        end else begin
            readdata <= rd_next;
            irq      <= |act_next;
            irq_id   <= lowest(act_next);
            pending  <= pending_next;
            mask     <= mask_next;
            edge_sel <= edge_next;
            prev     <= s_in;
        end
    end

endmodule

// File: tb/tb_core_irq_ctrl.sv
// tb_core_irq_ctrl: vector table, directed corner cases and random
// stimulus against a per-bit reference model of the interrupt controller.
module tb_core_irq_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic [N-1:0]  irq_in;
    logic          irq;
    logic [3:0]    irq_id;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_pend, m_mask, m_edge, m_prev, m_q1, m_q2;
    logic        exp_irq;
    logic [3:0]  exp_id;
    logic [15:0] exp_rd;

    typedef struct {
        logic [2:0]   a;
        logic         c;
        logic         w;
        logic [15:0]  d;
        logic [N-1:0] i;
        logic         e_irq;
        logic [3:0]   e_id;
        logic [15:0]  e_rd;
    } vec_t;

    core_irq_ctrl #(.NUM_IRQ(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq_in(irq_in),
        .irq(irq),
        .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] low_idx(input logic [15:0] v);
        for (int b = 0; b < 16; b++) begin
            if (v[b]) return 4'(b);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_edge = 0;
        m_prev = 0; m_q1 = 0; m_q2 = 0;
    endtask

    task automatic model_step();
        logic [15:0] s, np, nm, ne, act;
        logic wr;
        wr = chipselect && !write_n;
`ifdef CORE_IRQ_CTRL_SYNC_EN
        s = m_q2;
`else
        s = 16'(irq_in);
`endif
        act = m_pend & m_mask;
        case (address)
            3'd0: exp_rd = m_pend;
            3'd1: exp_rd = m_mask;
            3'd2: exp_rd = m_edge;
            3'd3: exp_rd = act;
            3'd4: exp_rd = (act != 0) ? {1'b1, 11'b0, low_idx(act)} : 16'h0;
            3'd5: exp_rd = s;
            default: exp_rd = 16'h0;
        endcase
        np = 0; nm = 0; ne = 0;
        for (int b = 0; b < N; b++) begin
            logic rise, set_b, clr_b;
            rise  = s[b] && !m_prev[b];
            set_b = (m_edge[b] ? rise : s[b])
                 || (wr && address == 3'd3 && writedata[b]);
            clr_b = wr && address == 3'd0 && writedata[b];
            if (set_b)      np[b] = 1'b1;
            else if (clr_b) np[b] = 1'b0;
            else            np[b] = m_pend[b];
            nm[b] = (wr && address == 3'd1) ? writedata[b] : m_mask[b];
            ne[b] = (wr && address == 3'd2) ? writedata[b] : m_edge[b];
        end
        m_pend = np; m_mask = nm; m_edge = ne;
        m_prev = s;
        m_q2 = m_q1;
        m_q1 = 16'(irq_in);
        exp_irq = (np & nm) != 0;
        exp_id  = low_idx(np & nm);
    endtask

    task automatic apply(input logic [2:0] a, input logic c, input logic w,
                         input logic [15:0] d, input logic [N-1:0] i);
        address = a; chipselect = c; write_n = w; writedata = d; irq_in = i;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ei,
                           input logic [3:0] eid, input logic [15:0] erd);
        chk({nm, ".irq"}, 16'(irq), 16'(ei));
        chk({nm, ".id"}, 16'(irq_id), 16'(eid));
        chk({nm, ".rd"}, readdata, erd);
    endtask

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{3'd1, 1, 0, 16'h0001, 8'h00, 0, 0, 16'h0000};
        tbl[1]  = '{3'd1, 0, 1, 16'h0000, 8'h01, 1, 0, 16'h0001};
        tbl[2]  = '{3'd4, 0, 1, 16'h0000, 8'h01, 1, 0, 16'h8000};
        tbl[3]  = '{3'd0, 1, 0, 16'h0001, 8'h01, 1, 0, 16'h0001};
        tbl[4]  = '{3'd0, 0, 1, 16'h0000, 8'h00, 1, 0, 16'h0001};
        tbl[5]  = '{3'd0, 1, 0, 16'h0001, 8'h00, 0, 0, 16'h0001};
        tbl[6]  = '{3'd0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000};
        tbl[7]  = '{3'd1, 1, 0, 16'h00FF, 8'h00, 0, 0, 16'h0001};
        tbl[8]  = '{3'd3, 1, 0, 16'h0090, 8'h00, 1, 4, 16'h0000};
        tbl[9]  = '{3'd0, 1, 0, 16'h0010, 8'h00, 1, 7, 16'h0090};
        tbl[10] = '{3'd0, 1, 0, 16'h0080, 8'h00, 0, 0, 16'h0080};
        tbl[11] = '{3'd1, 1, 0, 16'hFF00, 8'h00, 0, 0, 16'h00FF};
        tbl[12] = '{3'd1, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000};
        tbl[13] = '{3'd3, 1, 0, 16'hFF00, 8'h00, 0, 0, 16'h0000};
        tbl[14] = '{3'd0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000};
        tbl[15] = '{3'd5, 0, 1, 16'h0000, 8'h5A, 0, 0, 16'h005A};
        tbl[16] = '{3'd0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h005A};
        tbl[17] = '{3'd6, 1, 0, 16'hFFFF, 8'h00, 0, 0, 16'h0000};
        tbl[18] = '{3'd4, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000};

        reset_n = 1'b0;
        address = 0; chipselect = 0; write_n = 1; writedata = 0; irq_in = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 4'd0, 16'h0000);
        reset_n = 1'b1;

`ifndef CORE_IRQ_CTRL_SYNC_EN
        for (int k = 0; k < 19; k++) begin
            apply(tbl[k].a, tbl[k].c, tbl[k].w, tbl[k].d, tbl[k].i);
            chk_out($sformatf("vec%0d", k), tbl[k].e_irq, tbl[k].e_id, tbl[k].e_rd);
        end

        apply(3'd0, 1, 0, 16'h00FF, 8'h00);
        chk("edge.clr.rd", readdata, 16'h005A);
        apply(3'd2, 1, 0, 16'h0004, 8'h00);
        apply(3'd1, 1, 0, 16'h0004, 8'h00);
        chk("edge.idle.irq", 16'(irq), 16'h0);
        apply(3'd2, 0, 1, 16'h0000, 8'h04);
        chk_out("edge.pulse", 1'b1, 4'd2, 16'h0004);
        apply(3'd0, 0, 1, 16'h0000, 8'h00);
        chk_out("edge.after", 1'b1, 4'd2, 16'h0004);
        apply(3'd0, 1, 0, 16'h0004, 8'h00);
        chk("edge.w1c.irq", 16'(irq), 16'h0);
        apply(3'd0, 0, 1, 16'h0000, 8'h04);
        chk("edge.rise2.irq", 16'(irq), 16'h1);
        apply(3'd0, 1, 0, 16'h0004, 8'h04);
        chk("edge.w1c_hi.irq", 16'(irq), 16'h0);
        apply(3'd0, 0, 1, 16'h0000, 8'h04);
        chk_out("edge.hold", 1'b0, 4'd0, 16'h0000);
        apply(3'd0, 0, 1, 16'h0000, 8'h00);
        apply(3'd0, 1, 0, 16'h0004, 8'h04);
        chk_out("collide", 1'b1, 4'd2, 16'h0000);
        apply(3'd0, 0, 1, 16'h0000, 8'h04);
        chk("collide.rd", readdata, 16'h0004);

        apply(3'd1, 1, 0, 16'h0006, 8'h06);
        chk_out("lvl1", 1'b1, 4'd1, 16'h0004);
        apply(3'd0, 1, 0, 16'h0002, 8'h06);
        chk_out("lvl1.w1c_hi", 1'b1, 4'd1, 16'h0006);
        apply(3'd2, 1, 0, 16'h0006, 8'h06);
        apply(3'd0, 1, 0, 16'h0002, 8'h06);
        chk_out("e01.noedge", 1'b1, 4'd2, 16'h0006);
`endif

        // Asynchronous reset in the middle of operation
        apply(3'd3, 1, 0, 16'h0001, 8'h00);
        apply(3'd0, 1, 0, 16'h0000, 8'h00);
        chk("pre_rst.irq", 16'(irq), 16'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 4'd0, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(3'd1, 0, 1, 16'h0000, 8'h01);
        chk_out("post_rst.mask", 1'b0, 4'd0, 16'h0000);
        apply(3'd0, 0, 1, 16'h0000, 8'h01);
`ifdef CORE_IRQ_CTRL_SYNC_EN
        chk("post_rst.pend", readdata, 16'h0000);
`else
        chk("post_rst.pend", readdata, 16'h0001);
`endif

        // Random traffic against the reference model
        irq_in = '0;
        for (int k = 0; k < 600; k++) begin
            logic [2:0]   a;
            logic         c, w;
            logic [15:0]  d;
            logic [N-1:0] i;
            a = 3'($urandom_range(0, 7));
            c = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            i = ($urandom_range(0, 3) == 0) ? N'($urandom) : irq_in;
            apply(a, c, w, d, i);
            chk($sformatf("rnd%0d.irq", k), 16'(irq), 16'(exp_irq));
            chk($sformatf("rnd%0d.id", k), 16'(irq_id), 16'(exp_id));
            chk($sformatf("rnd%0d.rd", k), readdata, exp_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
